// File: rtl/nn_parameters_pkg.sv
// Shared constants and types for the stochastic neural-network layers
// (LFSR geometry, default dropout threshold, dropout FSM state type).
package nn_parameters;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Default drop probability; the threshold is the rate scaled onto the 16-bit draw range.
    localparam real         DROPOUT_RATE   = 0.5;
    localparam logic [15:0] DROPOUT_THRESH = 16'($rtoi(DROPOUT_RATE * 65536.0));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dropout_state_t;

endpackage

// File: rtl/nn_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed load; a zero seed
// is replaced by SEED so the register can never lock up at 0.
module nn_lfsr16
    import nn_parameters::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    // LFSR register: load has priority over step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            value <= (seed == 16'h0000) ? SEED : seed;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/dropout_layer_seq.sv
// Sequential dropout stage: captures a vector, zeroes elements whose LFSR draw
// is below drop_thresh (one element per cycle), then holds the result.
// Optional keep-scaling is enabled with the DROPOUT_SCALE_EN macro.
module dropout_layer_seq
    import nn_parameters::*;
#(
    parameter int          DATA_W    = 24,
    parameter int          VEC_LEN   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] SCALE_Q   = 16'h0100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            train_en,
    input  logic [15:0]                     drop_thresh,
    input  logic                            seed_load,
    input  logic [15:0]                     seed,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DATA_W-1:0]        in_vec [VEC_LEN],
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [DATA_W-1:0]        out_vec [VEC_LEN],
    output logic [$clog2(VEC_LEN+1)-1:0]    drop_count
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W = DATA_W + 16;
`ifdef DROPOUT_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{17{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{17{1'b1}}, {(DATA_W-1){1'b0}}};

    dropout_state_t                 state_r;
    logic [IDX_W-1:0]               index_r;
    logic signed [DATA_W-1:0]       vec_r [VEC_LEN];
    logic                           train_r;
    logic [15:0]                    thresh_r;

    logic [LFSR_W-1:0]              lfsr_s;
    logic                           lfsr_load_s;
    logic                           lfsr_step_s;
    logic signed [DATA_W-1:0]       elem_s;
    logic signed [DATA_W-1:0]       scaled_s;
    logic signed [DATA_W-1:0]       result_s;
    logic signed [PROD_W-1:0]       prod_s;
    logic signed [PROD_W-1:0]       shifted_s;
    logic                           drop_s;

    nn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_s),
        .seed  (seed),
        .step  (lfsr_step_s),
        .value (lfsr_s)
    );

    // Per-element datapath: draw comparison, optional Q8.8 scale with saturation
    always_comb begin
        lfsr_load_s = (state_r == IDLE) && seed_load;
        lfsr_step_s = (state_r == RUN) && train_r;
        elem_s      = vec_r[index_r];
        drop_s      = train_r && (lfsr_s < thresh_r);
        prod_s      = PROD_W'(elem_s) * PROD_W'($signed(SCALE_Q));
        shifted_s   = prod_s >>> 8;
        if (shifted_s > SAT_MAX) begin
            scaled_s = SAT_MAX[DATA_W-1:0];
        end else if (shifted_s < SAT_MIN) begin
            scaled_s = SAT_MIN[DATA_W-1:0];
        end else begin
            scaled_s = shifted_s[DATA_W-1:0];
        end
        if (drop_s) begin
            result_s = '0;
        end else if (SCALE_EN && train_r) begin
            result_s = scaled_s;
        end else begin
            result_s = elem_s;
        end
    end

    // Control FSM and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            drop_count <= '0;
            index_r    <= '0;
            train_r    <= 1'b0;
            thresh_r   <= 16'h0000;
            for (int i = 0; i < VEC_LEN; i++) begin
                out_vec[i] <= '0;
                vec_r[i]   <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vec_r      <= in_vec;
                        train_r    <= train_en;
                        thresh_r   <= drop_thresh;
                        index_r    <= '0;
                        drop_count <= '0;
                        in_ready   <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    out_vec[index_r] <= result_s;
                    if (drop_s) begin
                        drop_count <= drop_count + CNT_W'(1);
                    end
                    if (index_r == IDX_W'(VEC_LEN - 1)) begin
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        index_r <= index_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
